// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word type, defaults and memory-stage state encoding
package cpu_types_pkg;

    localparam int WORD_W_DEF    = 32;
    localparam int ALIGN_LSB_DEF = 2;

    typedef logic [WORD_W_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_ACCESS,
        MEM_DONE
    } memstate_t;

endpackage

// File: rtl/link_reg.sv
// rtl/link_reg.sv - LL/SC link register with snoop invalidation and combinational hit
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   access_addr   address of the access in flight (LL set / SW clear)
//   set_en        LL completed this cycle
//   store_en      local store completed this cycle (clears on address match)
//   sc_clear      SC captured this cycle (unconditional clear)
//   snoop_inval   remote write/invalidate observed
//   snoop_addr    address of the snoop
//   probe_addr    address checked by hit
//   hit           link valid, probe matches, and no same-cycle snoop on it
//   link_valid    link register state
module link_reg
    import cpu_types_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int ALIGN_LSB = ALIGN_LSB_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] access_addr,
    input  logic              set_en,
    input  logic              store_en,
    input  logic              sc_clear,
    input  logic              snoop_inval,
    input  logic [WORD_W-1:0] snoop_addr,
    input  logic [WORD_W-1:0] probe_addr,
    output logic              hit,
    output logic              link_valid
);

    localparam int TAG_W = WORD_W - ALIGN_LSB;

    logic [TAG_W-1:0] link_addr;
    logic [TAG_W-1:0] access_tag;
    logic [TAG_W-1:0] snoop_tag;
    logic [TAG_W-1:0] probe_tag;
    logic             snoop_cur;
    logic             snoop_set;
    logic             store_hit;

    // Byte-offset bits play no part in link matching.
    logic unused_offsets;
    assign unused_offsets = ^{access_addr[ALIGN_LSB-1:0],
                              snoop_addr[ALIGN_LSB-1:0],
                              probe_addr[ALIGN_LSB-1:0]};

    assign access_tag = access_addr[WORD_W-1:ALIGN_LSB];
    assign snoop_tag  = snoop_addr[WORD_W-1:ALIGN_LSB];
    assign probe_tag  = probe_addr[WORD_W-1:ALIGN_LSB];

    assign snoop_cur = snoop_inval && (snoop_tag == link_addr);
    // A snoop hitting the address being linked this very cycle must win.
    assign snoop_set = snoop_inval && (snoop_tag == access_tag);
    assign store_hit = store_en && (access_tag == link_addr);

    // Hit already reflects a snoop arriving in the same cycle.
    assign hit = link_valid && (probe_tag == link_addr) && !snoop_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (set_en) begin
            link_addr  <= access_tag;
            link_valid <= !snoop_set;
        end else if (sc_clear || store_hit || snoop_cur) begin
            link_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage controller: dcache request sequencing, stall, LL/SC
//
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   op_valid, MemRead, MemWrite EX/MEM instruction and access type
//   LL, SC                      load-linked / store-conditional qualifiers
//   aluOutport, store_data      effective address and store value
//   dhit, dload                 cache completion and read data
//   snoop_inval, snoop_addr     remote invalidation
//   dmemREN, dmemWEN            cache read/write requests
//   dmemaddr, dmemstore         cache address and write data
//   dmemload_out                load data or SC result to MEM/WB
//   mem_stall                   freezes upstream pipeline
//   memwb_wen                   MEM/WB latch write enable
//   link_valid                  link register state
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int ALIGN_LSB = ALIGN_LSB_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              op_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              LL,
    input  logic              SC,
    input  logic [WORD_W-1:0] aluOutport,
    input  logic [WORD_W-1:0] store_data,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    input  logic              snoop_inval,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] dmemload_out,
    output logic              mem_stall,
    output logic              memwb_wen,
    output logic              link_valid
);

    memstate_t         state;
    logic [WORD_W-1:0] op_addr;
    logic [WORD_W-1:0] op_data;
    logic              op_rd;
    logic              op_wr;
    logic              op_ll;
    logic              op_sc;
    logic [WORD_W-1:0] load_q;
    logic              ren_q;
    logic              wen_q;

    logic mem_op;
    logic link_hit;
    logic link_set;
    logic store_done;
    logic sc_capture;

    assign mem_op     = op_valid && (MemRead || MemWrite);
    assign sc_capture = (state == MEM_IDLE) && mem_op && SC;
    assign link_set   = (state == MEM_ACCESS) && dhit && op_rd && op_ll;
    assign store_done = (state == MEM_ACCESS) && dhit && op_wr;

    link_reg #(
        .WORD_W    (WORD_W),
        .ALIGN_LSB (ALIGN_LSB)
    ) u_link_reg (
        .clk         (CLK),
        .rst         (RST),
        .access_addr (op_addr),
        .set_en      (link_set),
        .store_en    (store_done),
        .sc_clear    (sc_capture),
        .snoop_inval (snoop_inval),
        .snoop_addr  (snoop_addr),
        .probe_addr  (aluOutport),
        .hit         (link_hit),
        .link_valid  (link_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= MEM_IDLE;
            op_addr <= '0;
            op_data <= '0;
            op_rd   <= 1'b0;
            op_wr   <= 1'b0;
            op_ll   <= 1'b0;
            op_sc   <= 1'b0;
            load_q  <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (mem_op) begin
                        op_addr <= aluOutport;
                        op_data <= store_data;
                        op_rd   <= MemRead;
                        op_wr   <= MemWrite;
                        op_ll   <= LL;
                        op_sc   <= SC;
                        if (SC && !link_hit) begin
                            // Failed SC never touches the cache.
                            load_q <= '0;
                            state  <= MEM_DONE;
                        end else begin
                            ren_q <= MemRead;
                            wen_q <= MemWrite;
                            state <= MEM_ACCESS;
                        end
                    end
                end
                MEM_ACCESS: begin
                    if (dhit) begin
                        ren_q <= 1'b0;
                        wen_q <= 1'b0;
                        if (op_sc) begin
                            load_q <= {{(WORD_W-1){1'b0}}, 1'b1};
                        end else if (op_rd) begin
                            load_q <= dload;
                        end
                        state <= MEM_DONE;
                    end
                end
                MEM_DONE: begin
                    state <= MEM_IDLE;
                end
                default: begin
                    state <= MEM_IDLE;
                    ren_q <= 1'b0;
                    wen_q <= 1'b0;
                end
            endcase
        end
    end

    assign dmemREN      = ren_q;
    assign dmemWEN      = wen_q;
    assign dmemaddr     = op_addr;
    assign dmemstore    = op_data;
    assign dmemload_out = load_q;

    // Capture cycle must stall combinationally so EX/MEM holds the op.
    assign mem_stall = !RST && (((state == MEM_IDLE) && mem_op) || (state == MEM_ACCESS));
    assign memwb_wen = RST || (state == MEM_DONE) || ((state == MEM_IDLE) && !mem_op);

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage controller between the EX/MEM latch and the MEM/WB latch of the pipelined MIPS core.
- Sequences data-cache read/write requests against the dhit handshake and stalls the pipeline until the access completes.
- Owns the LL/SC link register, including snoop invalidation.
- Presents load data, or the SC result, to the MEM/WB latch.

Parameters:
WORD_W, 32, data and address width
ALIGN_LSB, 2, low address bits ignored in link-address compare

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
op_valid  in  1  EX/MEM latch holds a live instruction
MemRead  in  1  load (LW or LL)
MemWrite  in  1  store (SW or SC)
LL  in  1  load-linked qualifier
SC  in  1  store-conditional qualifier
aluOutport  in  WORD_W  effective address
store_data  in  WORD_W  rt value to store
dhit  in  1  cache completes current request this cycle
dload  in  WORD_W  cache read data (valid with dhit)
snoop_inval  in  1  remote write/invalidate observed
snoop_addr  in  WORD_W  address of snoop_inval
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  WORD_W  cache address
dmemstore  out  WORD_W  cache write data
dmemload_out  out  WORD_W  to MEM/WB dmemload_in
mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
memwb_wen  out  1  to MEM/WB writeEN
link_valid  out  1  link register state (debug/verification)

Behaviour:
- One clock; reset is synchronous and active-high.
- On RST:
  - state=IDLE; link_valid=0; link_addr=0; op registers=0.
  - dmemREN=dmemWEN=0, dmemaddr=dmemstore=0, dmemload_out=0, mem_stall=0, memwb_wen=1.
- Reset mid-access: the request drops the cycle after RST and any dhit that cycle is ignored.
- mem_op = op_valid & (MemRead|MemWrite).
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No mem_op: mem_stall=0, memwb_wen=1 (ALU/halt/bubble pass-through, zero added latency).
  - mem_op: capture addr, data, rd/wr, LL, SC into op registers; mem_stall=1, memwb_wen=0.
  - SC with link hit (link_valid & addr[W-1:ALIGN_LSB]==link_addr, evaluated after same-cycle snoop update): go to ACCESS as a write.
  - SC with link miss: load_q=0, go to DONE, issue no write.
  - Any other mem_op: go to ACCESS.
- ACCESS:
  - dmemREN/dmemWEN driven from registered op; dmemaddr/dmemstore from registered op; all held stable until dhit.
  - mem_stall=1.
  - On dhit: read latches load_q=dload; SC latches load_q=1; then go to DONE.
  - No timeout; waits indefinitely.
- DONE (exactly one cycle):
  - Requests deasserted, mem_stall=0, memwb_wen=1, dmemload_out=load_q.
  - Upstream latches advance this cycle; next state IDLE.
- Minimum mem-op latency: 3 cycles (IDLE capture, ACCESS with dhit, DONE). Failed SC: 2 cycles.
- dmemload_out holds load_q at all times; it is written only at dhit or on SC fail.
- Link register:
  - LL completion (dhit) sets link_valid=1, link_addr=addr[W-1:ALIGN_LSB].
  - Any SC capture clears link_valid, pass or fail.
  - Local SW to link_addr clears it at dhit.
  - snoop_inval with snoop_addr matching link_addr clears it in any state.
- Simultaneous events:
  - snoop clear and LL set on the same cycle/address: cleared wins.
  - Snoop arriving in the SC capture cycle makes the SC fail.

Decomposition:
- cpu_types_pkg adds: typedef enum logic [1:0] {MEM_IDLE, MEM_ACCESS, MEM_DONE} memstate_t; word_t reused for addr/data.
- One sub-module, link_reg: holds link_valid/link_addr; set, clear, snoop-compare logic; exposes combinational hit.

Test Plan:
- LW 0x100, dhit 2 cycles after request, dload=0xDEADBEEF -> mem_stall high 4 cycles, memwb_wen pulses once, dmemload_out=0xDEADBEEF.
- ALU op (no MemRead/MemWrite) streamed every cycle -> mem_stall=0, memwb_wen=1 continuously, no dmemREN/WEN.
- LL 0x200 then SC 0x200 data 0x5 -> dmemWEN with dmemstore=0x5, dmemload_out=1, link_valid=0 after.
- LL 0x200, snoop_inval 0x200, SC 0x200 -> no dmemWEN, dmemload_out=0, SC takes 2 cycles.
- LL 0x200, snoop_inval 0x204, SC 0x200 -> SC succeeds (different word), dmemload_out=1.
- RST asserted in ACCESS with dmemREN=1 -> next cycle REN=0, state IDLE, link_valid=0, late dhit ignored.
